// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int W_CPU    = 32;
  localparam int W_OPCODE = 4;
  localparam int W_ID     = 1;
  localparam int W_CNT    = 4;  // holds EXEC_CYCLES-1 for EXEC_CYCLES in 1..15

  localparam logic [W_OPCODE-1:0] OP_ADD = 4'd0;
  localparam logic [W_OPCODE-1:0] OP_SUB = 4'd1;
  localparam logic [W_OPCODE-1:0] OP_AND = 4'd2;
  localparam logic [W_OPCODE-1:0] OP_OR  = 4'd3;
  localparam logic [W_OPCODE-1:0] OP_XOR = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [W_OPCODE-1:0] op;
    logic [W_CPU-1:0]    a;
    logic [W_CPU-1:0]    b;
  } alu_req_t;

  // Signed overflow of an addition, given the sign bits of both addends and the sum.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: purely combinational ALU (ADD/SUB/AND/OR/XOR) with signed overflow and zero flag.
// Latency: combinational, zero cycles.
// Backpressure: none; the arbiter owns all timing.
// Ports: i_op/i_a/i_b operation in; o_r result, o_overflow signed overflow, o_zero result==0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [W_OPCODE-1:0] i_op,
  input  logic [W_CPU-1:0]    i_a,
  input  logic [W_CPU-1:0]    i_b,
  output logic [W_CPU-1:0]    o_r,
  output logic                o_overflow,
  output logic                o_zero
);

  always_comb begin
    o_r        = '0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_r        = i_a + i_b;
        o_overflow = add_ovf(i_a[W_CPU-1], i_b[W_CPU-1], o_r[W_CPU-1]);
      end
      OP_SUB: begin
        // a - b == a + ~b + 1, so the overflow rule applies to a and ~b.
        o_r        = i_a - i_b;
        o_overflow = add_ovf(i_a[W_CPU-1], ~i_b[W_CPU-1], o_r[W_CPU-1]);
      end
      OP_AND:  o_r = i_a & i_b;
      OP_OR:   o_r = i_a | i_b;
      OP_XOR:  o_r = i_a ^ i_b;
      default: o_r = '0;  // unsupported opcodes produce zero, no overflow
    endcase
  end

  assign o_zero = (o_r == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter granting one of two requesters a shared ALU, one op in flight.
// Latency: accept in cycle N -> rsp_valid in cycle N+EXEC_CYCLES+1; one op per EXEC_CYCLES+2 cycles max.
// Backpressure: rsp_ready low holds the response indefinitely; both reqN_ready stay low until it drains.
// Ports: clk/rst_n (sync, active-low); reqN_valid/ready/op/a/b per requester;
//        rsp_valid/ready/id/r/overflow/zero result channel; busy = not idle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [W_OPCODE-1:0] req0_op,
  input  logic [W_CPU-1:0]    req0_a,
  input  logic [W_CPU-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [W_OPCODE-1:0] req1_op,
  input  logic [W_CPU-1:0]    req1_a,
  input  logic [W_CPU-1:0]    req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W_ID-1:0]     rsp_id,
  output logic [W_CPU-1:0]    rsp_r,
  output logic                rsp_overflow,
  output logic                rsp_zero,
  output logic                busy
);

  localparam logic [W_CNT-1:0] CNT_LOAD = W_CNT'(EXEC_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;     // requester granted most recently
  logic [W_CNT-1:0] r_cnt;
  alu_req_t         r_req;
  logic [W_ID-1:0]  r_id;

  logic             w_grant;
  logic             w_idle;
  logic             w_accept;
  alu_req_t         w_sel_req;
  logic [W_CPU-1:0] w_alu_r;
  logic             w_alu_ovf;
  logic             w_alu_zero;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = ~r_last;
    else if (req1_valid)          w_grant = 1'b1;
  end

  // Gating with rst_n keeps both readies low while reset is asserted.
  assign w_idle     = (r_state == ST_IDLE) && rst_n;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;
  assign w_accept   = req0_ready || req1_ready;

  always_comb begin
    w_sel_req = w_grant ? '{op: req1_op, a: req1_a, b: req1_b}
                        : '{op: req0_op, a: req0_a, b: req0_b};
  end

  // ALU sees only latched operands, so requester lines are free to change mid-op.
  alu_arbiter_alu u_alu (
    .i_op       (r_req.op),
    .i_a        (r_req.a),
    .i_b        (r_req.b),
    .o_r        (w_alu_r),
    .o_overflow (w_alu_ovf),
    .o_zero     (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_state_nxt = ST_EXEC;
      ST_EXEC: if (r_cnt == '0)    w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)      w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last       <= 1'b1;
      r_req        <= '0;
      r_id         <= '0;
      rsp_id       <= '0;
      rsp_r        <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (w_accept) begin
      r_req  <= w_sel_req;
      r_id   <= w_grant;
      r_last <= w_grant;
      r_cnt  <= CNT_LOAD;
    end else if (r_state == ST_EXEC) begin
      if (r_cnt == '0) begin
        rsp_id       <= r_id;
        rsp_r        <= w_alu_r;
        rsp_overflow <= w_alu_ovf;
        rsp_zero     <= w_alu_zero;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);

endmodule
